data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
Data-memory responder for the pipelined core's memory stage. It accepts load/store requests from the stage and returns load data on mem_read_result. It stalls the pipeline for one cycle per load. It holds a word-addressed RAM plus a small MMIO window: a free-running cycle counter, an LED register and an error/status register.

Parameters:
DEPTH_WORDS, 1024, RAM depth in 32-bit words; must be a power of 2.
MMIO_BASE, 32'h0001_0000, byte base address of the MMIO window; 16-byte aligned.
ERR_DATA, 32'hDEAD_BEEF, load data returned for a faulting load.

Ports:
clk  input  1  core clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset; state clears when reset=0.
mem_read  input  1  load request; held stable by the core while mem_stall=1.
mem_write  input  1  store request; single cycle.
mem_addr  input  32  byte address (ALU result of the memory stage).
mem_write_data  input  32  store data.
mem_byte_en  input  4  store byte lanes; bit i writes bits [8i+7:8i].
mem_read_result  output  32  load data, valid in the RESP cycle.
mem_stall  output  1  pipeline stall request (combinational).
led_out  output  32  LED register contents.
err  output  1  sticky fault flag.

Behaviour:
- Reset (reset=0, async) clears the following:
  - state=IDLE, mem_read_result=0, led_out=0, err=0, cycle counter=0.
  - RAM contents are not cleared.
  - mem_stall=0 while in reset.
- Address decode:
  - RAM hit when mem_addr < DEPTH_WORDS*4; word index = mem_addr[log2(DEPTH_WORDS)+1:2].
  - MMIO hit when mem_addr[31:4]==MMIO_BASE[31:4].
  - Offsets: 0x0 cycle counter (RO), 0x4 led_out (RW), 0x8 status (bit0=err; bits 31:1 read 0).
  - Offset 0xC and all other addresses are unmapped.
- Fault conditions set err on the faulting edge:
  - mem_addr[1:0]!=0 on any access.
  - Unmapped address.
  - mem_read and mem_write both high in IDLE.
- Fault handling:
  - A faulting store modifies nothing.
  - A faulting load still takes 2 cycles and returns ERR_DATA.
  - err clears only on reset, or on a store to offset 0x8 with mem_write_data[0]=1 and mem_byte_en[0]=1. Clear wins over a same-edge set from the same access.
- Stores:
  - Zero-latency, no stall.
  - RAM or LED bytes are updated at the rising edge where state==IDLE and mem_write=1; only enabled lanes are written.
  - Stores to the counter offset are ignored and do not raise a fault.
  - When mem_read and mem_write are both high, the store is performed (if otherwise legal), the load is dropped, err is set and the FSM stays IDLE.
- FSM states: IDLE, RESP.
  - IDLE with mem_read=1 and mem_write=0:
    - mem_stall=1 combinationally.
    - On the edge, load data is captured into mem_read_result and the FSM goes to RESP.
    - RAM is read synchronously; MMIO values are the pre-edge values (counter value before its increment).
  - RESP:
    - mem_stall=0; mem_read_result holds the captured data.
    - Next edge goes to IDLE unconditionally; the core advances past the load on that same edge.
  - Load latency: the request cycle plus 1; back-to-back loads cost 2 cycles each.
  - mem_read_result holds its last value until the next load capture.
  - A store presented during RESP is ignored. The core cannot present one, because the load occupies the stage.
- Cycle counter:
  - Increments by 1 every clock outside reset.
  - Wraps from 32'hFFFF_FFFF to 0 with no flag.
- Reset asserted mid-load (state RESP or stalled IDLE): the FSM returns to IDLE and mem_stall drops immediately. The core's own reset re-presents or discards the request.
- RAM writes and reads use a single port; no read-during-write case exists because a store and a load never share an edge.

Test Plan:
- Store 32'h1234_5678 to addr 0x10 with byte_en 4'hF, then load 0x10 → mem_stall=1 for exactly 1 cycle; next cycle mem_read_result=32'h1234_5678; err=0.
- Store 32'hAABB_CCDD with byte_en 4'b0101 over 0x10 previously holding 32'h1234_5678 → load 0x10 returns 32'h12BB_56DD.
- Release reset, wait 10 cycles, load MMIO_BASE+0 → returned value equals the counter value at the capture edge (golden model). Force counter near 32'hFFFF_FFFE and check wrap to 0.
- Fault clearing:
  - Load 0x13 (misaligned) → returns 32'hDEAD_BEEF after 1 stall cycle; err=1.
  - Load MMIO_BASE+8 → 32'h0000_0001.
  - Store 1 to MMIO_BASE+8 → err=0.
- mem_read=mem_write=1 at addr 0x20 with data 32'h0000_00FF → no stall; RAM[8]=32'h0000_00FF; err=1.
- Two back-to-back loads from 0x0 and 0x4 → stall pattern 1,0,1,0 over 4 cycles.
- Assert reset during the stall cycle → mem_stall=0, led_out=0, err=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: memory-stage load/store bus between the core and the data memory
interface data_mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_read_result;
    logic        mem_stall;
    modport master (
        output mem_read, mem_write, mem_addr, mem_write_data, mem_byte_en,
        input  mem_read_result, mem_stall
    );
    modport slave (
        input  mem_read, mem_write, mem_addr, mem_write_data, mem_byte_en,
        output mem_read_result, mem_stall
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM plus cycle-counter/LED/status MMIO window, one stall cycle per load
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h0001_0000,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF,
    parameter logic [31:0] CNT_INIT    = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus,
    output logic [31:0]          led_out,
    output logic                 err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;
    typedef enum logic {IDLE, RESP} state_t;
    state_t state;
    logic [31:0] ram [DEPTH_WORDS];
    logic [31:0] cycle_cnt;
    logic [31:0] mmio_rd;
    logic [AW-1:0] idx;
    logic idle, ram_hit, mmio_hit, sel_cnt, sel_led, sel_stat, bad_addr;
    logic load, store, err_set, err_clr;
    assign idx      = bus.mem_addr[AW+1:2];
    assign ram_hit  = {1'b0, bus.mem_addr} < RAM_BYTES;
    assign mmio_hit = !ram_hit && bus.mem_addr[31:4] == MMIO_BASE[31:4];
    assign sel_cnt  = mmio_hit && bus.mem_addr[3:2] == 2'd0;
    assign sel_led  = mmio_hit && bus.mem_addr[3:2] == 2'd1;
    assign sel_stat = mmio_hit && bus.mem_addr[3:2] == 2'd2;
    assign bad_addr = bus.mem_addr[1:0] != 2'b00 || !(ram_hit || sel_cnt || sel_led || sel_stat);
    assign idle     = state == IDLE;
    assign load     = idle && bus.mem_read && !bus.mem_write;
    // a simultaneous read+write still performs a legal store; only the load is dropped
    assign store    = idle && bus.mem_write && !bad_addr;
    assign err_set  = idle && (bus.mem_read || bus.mem_write) && (bad_addr || (bus.mem_read && bus.mem_write));
    assign err_clr  = store && sel_stat && bus.mem_write_data[0] && bus.mem_byte_en[0];
    assign bus.mem_stall = reset && load;
    assign mmio_rd  = sel_cnt ? cycle_cnt : sel_led ? led_out : {31'b0, err};
    always_ff @(posedge clk)
        if (reset && store && ram_hit)
            for (int i = 0; i < 4; i++)
                if (bus.mem_byte_en[i]) ram[idx][8*i +: 8] <= bus.mem_write_data[8*i +: 8];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            bus.mem_read_result <= '0;
            led_out             <= '0;
            err                 <= 1'b0;
            cycle_cnt           <= CNT_INIT;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            state     <= load ? RESP : IDLE;
            if (load) bus.mem_read_result <= bad_addr ? ERR_DATA : ram_hit ? ram[idx] : mmio_rd;
            if (store && sel_led)
                for (int i = 0; i < 4; i++)
                    if (bus.mem_byte_en[i]) led_out[8*i +: 8] <= bus.mem_write_data[8*i +: 8];
            err <= err_clr ? 1'b0 : err_set ? 1'b1 : err;
        end
    end
endmodule
